// File: rtl/ysyx_210247_clint_mh.sv
// Multi-hart core-local interruptor: a prescaled 64-bit mtime, one mtimecmp
// and one MSIP bit per hart, behind a valid/ready request channel with a
// registered, one-outstanding response channel. The mtip/msip outputs are raw;
// any gating by mstatus.MIE or mie happens in the CSR unit.
module ysyx_210247_clint_mh #(
  parameter int unsigned NHART        = 2,
  parameter int unsigned TICK_DIV     = 2,
  parameter logic [63:0] MTIMECMP_RST = 64'd700000,
  parameter int unsigned AW           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic             req_wen,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [63:0]      mtime_o,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  localparam int unsigned   DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam int unsigned   HW       = 4;  // hart index width, up to 16 harts

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_MSIP,
    TGT_MTIMECMP,
    TGT_MTIME
  } tgt_e;

  // Byte-wise merge of write data into an existing 64-bit value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Architectural state
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q [NHART];
  logic [63:0]      mtimecmp_d [NHART];
  logic [NHART-1:0] msip_q, msip_d;

  // Response channel state
  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  // Request decode
  logic [31:0]      addr_w;
  tgt_e             tgt;
  logic [HW-1:0]    hart;
  logic             lane_hi;
  logic             accept;
  logic             tick;
  logic [63:0]      rd_data;

  assign addr_w    = 32'(req_addr);
  assign lane_hi   = req_addr[2];
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign tick      = (div_cnt_q == DIV_LAST);

  // Map the byte offset onto a register class and hart index.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    tgt  = TGT_NONE;
    hart = '0;
    if (addr_w == 32'h0000_BFF8) begin
      tgt = TGT_MTIME;
    end else if ((addr_w < 32'(4 * NHART)) && (addr_w[1:0] == 2'b00)) begin
      tgt  = TGT_MSIP;
      hart = addr_w[5:2];
    end else if ((addr_w >= 32'h0000_4000) &&
                 (addr_w < 32'h0000_4000 + 32'(8 * NHART)) &&
                 (addr_w[2:0] == 3'b000)) begin
      tgt  = TGT_MTIMECMP;
      hart = addr_w[6:3];
    end
  end

  // Read mux over pre-edge register values; MSIP sits in the lane picked by addr[2].
  always_comb begin
    rd_data = '0;
    case (tgt)
      TGT_MSIP: begin
        for (int h = 0; h < NHART; h++) begin
          if (hart == HW'(h)) begin
            rd_data = lane_hi ? {31'd0, msip_q[h], 32'd0} : {63'd0, msip_q[h]};
          end
        end
      end
      TGT_MTIMECMP: begin
        for (int h = 0; h < NHART; h++) begin
          if (hart == HW'(h)) rd_data = mtimecmp_q[h];
        end
      end
      TGT_MTIME: rd_data = mtime_q;
      default:   rd_data = '0;
    endcase
  end

  // Prescaler, mtime increment and register writes; a write to MTIME beats the tick.
  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + DW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (accept && req_wen) begin
      case (tgt)
        TGT_MSIP: begin
          for (int h = 0; h < NHART; h++) begin
            if ((hart == HW'(h)) && req_wstrb[lane_hi ? 4 : 0]) begin
              msip_d[h] = req_wdata[lane_hi ? 32 : 0];
            end
          end
        end
        TGT_MTIMECMP: begin
          for (int h = 0; h < NHART; h++) begin
            if (hart == HW'(h)) begin
              mtimecmp_d[h] = merge_bytes(mtimecmp_q[h], req_wdata, req_wstrb);
            end
          end
        end
        TGT_MTIME: mtime_d = merge_bytes(mtime_q, req_wdata, req_wstrb);
        default:   ;
      endcase
    end
  end

  // Response: load on accept, hold until consumed, drop when consumed with nothing new.
  always_comb begin
    rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_rdata_d = req_wen ? 64'd0 : rd_data;
      rsp_err_d   = (tgt == TGT_NONE);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      div_cnt_q   <= '0;
      mtime_q     <= '0;
      msip_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      // NOTE: the compare array is architectural state with a defined reset
      // value, so it is reset here rather than left to a RAM macro.
      for (int h = 0; h < NHART; h++) begin
        mtimecmp_q[h] <= MTIMECMP_RST;
      end
    end else begin
      div_cnt_q   <= div_cnt_d;
      mtime_q     <= mtime_d;
      msip_q      <= msip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      for (int h = 0; h < NHART; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
    end
  end

  // Interrupt lines come purely from registered state.
  always_comb begin
    for (int h = 0; h < NHART; h++) begin
      mtip[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  assign msip      = msip_q;
  assign mtime_o   = mtime_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_210247_clint_mh.sv
// Self-checking bench for the multi-hart CLINT: directed steps followed by a
// randomized phase, every cycle compared against a transaction-level model.
module tb_ysyx_210247_clint_mh;

  localparam int          NHART    = 2;
  localparam int          TICK_DIV = 2;
  localparam logic [63:0] CMP_RST  = 64'd700000;
  localparam int          AW       = 16;

  localparam int K_NONE  = 0;
  localparam int K_MSIP  = 1;
  localparam int K_CMP   = 2;
  localparam int K_MTIME = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic             req_wen;
  logic [63:0]      req_wdata;
  logic [7:0]       req_wstrb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_rdata;
  logic             rsp_err;
  logic [63:0]      mtime_o;
  logic [NHART-1:0] mtip;
  logic [NHART-1:0] msip;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0]      m_mtime;
  logic [63:0]      m_cmp [NHART];
  logic [NHART-1:0] m_msip;
  longint unsigned  m_cyc;
  bit               m_rsp_valid;
  logic [63:0]      m_rsp_rdata;
  bit               m_rsp_err;

  ysyx_210247_clint_mh #(
    .NHART(NHART), .TICK_DIV(TICK_DIV), .MTIMECMP_RST(CMP_RST), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mtime_o(mtime_o), .mtip(mtip), .msip(msip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [15:0] a, output int kind, output int h);
    kind = K_NONE;
    h    = 0;
    if (a == 16'hBFF8) kind = K_MTIME;
    for (int i = 0; i < NHART; i++) begin
      if (a == 16'(4 * i))          begin kind = K_MSIP; h = i; end
      if (a == 16'(16'h4000 + 8*i)) begin kind = K_CMP;  h = i; end
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mtime     = '0;
    m_msip      = '0;
    m_cyc       = 0;
    m_rsp_valid = 0;
    m_rsp_rdata = '0;
    m_rsp_err   = 0;
    for (int i = 0; i < NHART; i++) m_cmp[i] = CMP_RST;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          acc;
    int          kind;
    int          h;
    int          lane;
    logic [63:0] nxt;
    if (rst) begin
      model_reset();
      return;
    end
    acc = req_valid && (!m_rsp_valid || rsp_ready);
    nxt = ((m_cyc % TICK_DIV) == TICK_DIV - 1) ? m_mtime + 64'd1 : m_mtime;
    if (acc) begin
      lookup(req_addr, kind, h);
      lane        = req_addr[2] ? 32 : 0;
      m_rsp_valid = 1;
      m_rsp_err   = (kind == K_NONE);
      m_rsp_rdata = '0;
      if (!req_wen) begin
        case (kind)
          K_MSIP:  m_rsp_rdata = 64'(m_msip[h]) << lane;
          K_CMP:   m_rsp_rdata = m_cmp[h];
          K_MTIME: m_rsp_rdata = m_mtime;
          default: m_rsp_rdata = '0;
        endcase
      end else begin
        case (kind)
          K_MSIP:  if (req_wstrb[lane/8]) m_msip[h] = req_wdata[lane];
          K_CMP:   m_cmp[h] = merge(m_cmp[h], req_wdata, req_wstrb);
          K_MTIME: nxt = merge(m_mtime, req_wdata, req_wstrb);
          default: ;
        endcase
      end
    end else if (rsp_ready) begin
      m_rsp_valid = 0;
    end
    m_mtime = nxt;
    m_cyc++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [NHART-1:0] exp_mtip;
    for (int i = 0; i < NHART; i++) exp_mtip[i] = (m_mtime >= m_cmp[i]);
    chk({tag, "/mtime"},     mtime_o,             m_mtime);
    chk({tag, "/mtip"},      64'(mtip),           64'(exp_mtip));
    chk({tag, "/msip"},      64'(msip),           64'(m_msip));
    chk({tag, "/rsp_valid"}, 64'(rsp_valid),      64'(m_rsp_valid));
    chk({tag, "/req_ready"}, 64'(req_ready),      64'(!m_rsp_valid || rsp_ready));
    if (m_rsp_valid) begin
      chk({tag, "/rdata"},   rsp_rdata,           m_rsp_rdata);
      chk({tag, "/err"},     64'(rsp_err),        64'(m_rsp_err));
    end
  endtask

  task automatic do_req(input string tag, input logic wen, input logic [15:0] addr,
                        input logic [63:0] wdata, input logic [7:0] strb);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    cycle();
    req_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    check_all("reset");
    chk("reset_mtime", mtime_o, 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd1);

    // Idle prescaled count
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_all("idle");
    end
    chk("idle_mtime5", mtime_o, 64'd5);
    chk("idle_mtip",   64'(mtip), 64'd0);
    do_req("rd_cmp1", 1'b0, 16'h4008, 64'd0, 8'h00);
    chk("rd_cmp1_val", rsp_rdata, 64'd700000);
    chk("rd_cmp1_vld", 64'(rsp_valid), 64'd1);

    // Timer compare on hart 1
    do_req("wr_cmp1", 1'b1, 16'h4008, 64'd20, 8'hFF);
    for (int i = 0; i < 200 && m_mtime < 64'd20; i++) begin
      cycle();
      check_all("wait20");
    end
    chk("mtip1_at20", 64'(mtip), 64'b10);
    chk("mtime_is20", mtime_o, 64'd20);
    do_req("wr_cmp1_max", 1'b1, 16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    chk("mtip1_clear", 64'(mtip), 64'd0);

    // Software interrupt lane and strobe handling
    do_req("msip1_set", 1'b1, 16'h0004, 64'h1_0000_0000, 8'hF0);
    chk("msip_10", 64'(msip), 64'b10);
    do_req("msip1_lostrb", 1'b1, 16'h0004, 64'h1_0000_0000, 8'h0F);
    do_req("msip1_lostrb0", 1'b1, 16'h0004, 64'h0, 8'h0F);
    chk("msip_hold", 64'(msip), 64'b10);
    do_req("msip0_set", 1'b1, 16'h0000, 64'h1, 8'h01);
    do_req("msip0_clr", 1'b1, 16'h0000, 64'h0, 8'h01);

    // MTIME write on a tick edge wins, then wraps
    for (int i = 0; i < 4 && (m_cyc % TICK_DIV) != TICK_DIV - 1; i++) cycle();
    do_req("wr_mtime", 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    chk("mtime_fffe", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
    do_req("rd_mtime", 1'b0, 16'hBFF8, 64'd0, 8'h00);
    chk("rd_mtime_val", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_all("wrap");
    end
    chk("mtime_wrap0", mtime_o, 64'd0);

    // Backpressure and back-to-back accept
    rsp_ready = 1'b0;
    do_req("bp_rd", 1'b0, 16'h4000, 64'd0, 8'h00);
    req_valid = 1'b1;
    req_addr  = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_all("bp_hold");
      chk("bp_rdata", rsp_rdata, 64'd700000);
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    check_all("b2b");
    chk("b2b_rdata", rsp_rdata, 64'h1_0000_0000);
    chk("b2b_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b0;
    cycle();
    check_all("b2b_drain");

    // Unmapped addresses
    do_req("err_8000", 1'b0, 16'h8000, 64'd0, 8'h00);
    chk("err_8000_e", 64'(rsp_err), 64'd1);
    chk("err_8000_d", rsp_rdata, 64'd0);
    do_req("err_0008", 1'b0, 16'h0008, 64'd0, 8'h00);
    chk("err_0008_e", 64'(rsp_err), 64'd1);
    do_req("err_wr", 1'b1, 16'h0008, 64'h1, 8'hFF);

    // Reset with a response pending; the write in that cycle must not land
    rsp_ready = 1'b0;
    do_req("pre_rst", 1'b0, 16'h4010, 64'd0, 8'h00);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 16'h4000;
    req_wdata = 64'd5;
    req_wstrb = 8'hFF;
    cycle();
    chk("rst_drop", 64'(rsp_valid), 64'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check_all("post_rst");
    do_req("rd_cmp0", 1'b0, 16'h4000, 64'd0, 8'h00);
    chk("rd_cmp0_val", rsp_rdata, 64'd700000);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0:       req_addr = 16'h0000;
        1:       req_addr = 16'h0004;
        2:       req_addr = 16'h4000;
        3:       req_addr = 16'h4008;
        4:       req_addr = 16'hBFF8;
        5:       req_addr = 16'h0008;
        default: req_addr = 16'($urandom);
      endcase
      req_valid = 1'($urandom_range(0, 1));
      req_wen   = 1'($urandom_range(0, 1));
      req_wdata = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 400))};
      req_wstrb = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_210247_clint_mh.md
Name: ysyx_210247_clint_mh

Overview:
- Multi-hart core-local interruptor; the parametrised successor to the single-hart timer block.
- Holds a prescaled 64-bit mtime, one mtimecmp per hart, and one MSIP software-interrupt bit per hart.
- Register access is a valid/ready request channel plus a registered response channel, one transaction outstanding.
- Drives raw, ungated mtip/msip per hart to the CSR units. Gating by mstatus.MIE/mie stays in the CSR unit.

Parameters:
- NHART, 2, number of harts (1..16).
- TICK_DIV, 2, clk cycles per mtime increment (1 = every cycle; must be >= 1).
- MTIMECMP_RST, 700000, reset value of every mtimecmp.
- AW, 16, request address width (offset inside the CLINT window).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  AW  byte offset.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  64  write data.
- req_wstrb  in  8  byte enables (writes only).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  64  read data (0 for writes).
- rsp_err  out  1  unmapped address.
- mtime_o  out  64  current mtime, feeds the time CSR.
- mtip  out  NHART  mtip[h] = (mtime >= mtimecmp[h]), unsigned compare.
- msip  out  NHART  msip[h] = MSIP[h] bit 0.

Behaviour:
- Map:
  - MSIP[h] at 0x0000+4h: 32-bit; only bit 0 is implemented, other bits read 0.
  - MTIMECMP[h] at 0x4000+8h: 64-bit.
  - MTIME at 0xBFF8: 64-bit.
  - Any other offset, or h >= NHART: rsp_err=1, rdata 0, no state change.
- 32-bit MSIP data sits in lane req_addr[2] (bits 63:32 if req_addr[2]=1, else 31:0). A write updates MSIP only if the strobe for byte 0 of that lane is set.
- 64-bit registers are written bytewise per req_wstrb.
- req_ready = !rsp_valid || rsp_ready, so a new request may be accepted in the same cycle the old response is consumed.
- On the accept edge:
  - a write updates the target register;
  - a read captures the register's pre-edge value into rsp_rdata;
  - rsp_valid <= 1 and rsp_err is set as above.
  - Response latency is exactly 1 cycle after accept.
- rsp_valid, rsp_rdata and rsp_err hold stable until consumed. rsp_valid clears on consume unless a new request is accepted in the same cycle.
- Prescaler: div_cnt counts 0..TICK_DIV-1. When div_cnt == TICK_DIV-1, div_cnt <= 0 and mtime <= mtime+1. With TICK_DIV=1, mtime increments every cycle.
- mtime wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 silently.
- A software write to MTIME on a tick edge wins; the increment is dropped. div_cnt is unaffected by writes.
- mtip/msip/mtime_o are derived from registered state only, with no combinational path from request inputs. A write is visible on mtip/msip the cycle after accept.
- Reset values:
  - mtime=0, div_cnt=0, all mtimecmp=MTIMECMP_RST, all MSIP=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1;
  - therefore mtip=0 and msip=0.
- Reset mid-transaction drops any pending response; no write from the aborted cycle lands.

Test Plan:
- After reset with TICK_DIV=2, no requests for 10 cycles -> mtime_o=5, mtip=0, msip=0; read 0x4008 -> rsp_rdata=700000 one cycle after accept.
- Write MTIMECMP[1] (0x4008)=20, wstrb=0xFF -> mtip[1] rises on the cycle mtime reaches 20, mtip[0] stays 0; rewrite it to 0xFFFF_FFFF_FFFF_FFFF -> mtip[1]=0 on the next cycle.
- Write 0x0004 with wdata=0x1_0000_0000 and wstrb=0xF0 -> msip=2'b10; the same write with wstrb=0x0F -> no change.
- Write MTIME=0xFFFF_FFFF_FFFF_FFFE coincident with a tick edge -> mtime reads FFFE, then wraps to 0 two ticks later.
- Hold rsp_ready=0 for 3 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready=0; raise rsp_ready while req_valid=1 -> back-to-back accept with no bubble.
- Read 0x8000 and 0x0008 (NHART=2) -> rsp_err=1, rsp_rdata=0; assert rst while rsp_valid=1 -> rsp_valid=0 on the next cycle.
